// File: rtl/bsg_mcl_tx_packer.sv
// Word FIFO feeding a packet assembler: gathers words_per_pkt_p 32-bit words into one wide packet.
// Optional feature macro: BSG_MCL_TX_DROP_CNT_EN enables the saturating dropped-push counter.
module bsg_mcl_tx_packer #(
  parameter int words_per_pkt_p = 4,
  parameter int fifo_els_p      = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [31:0]                       txs_i,
  input  logic                              txs_v_i,
  output logic                              txs_ready_o,
  input  logic                              clr_isr_txc_i,
  output logic [32*words_per_pkt_p-1:0]     pkt_o,
  output logic                              pkt_v_o,
  input  logic                              pkt_ready_i,
  output logic [$clog2(fifo_els_p):0]       vacancy_o,
  output logic                              isr_txc_o,
  output logic [15:0]                       drop_cnt_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam int wc_w_lp  = $clog2(words_per_pkt_p);
  localparam logic [wc_w_lp-1:0]  last_wc_lp = wc_w_lp'(words_per_pkt_p - 1);
  localparam logic [cnt_w_lp-1:0] els_lp     = cnt_w_lp'(fifo_els_p);

  typedef enum logic {E_FILL, E_SEND} state_e;

  state_e                                state_q, state_d;
  logic [ptr_w_lp-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]                   count_q, count_d;
  logic [wc_w_lp-1:0]                    word_cnt_q, word_cnt_d;
  logic [words_per_pkt_p-1:0][31:0]      pkt_q, pkt_d;
  logic                                  isr_txc_q, isr_txc_d;
  logic [31:0]                           mem_q [fifo_els_p];

  logic full, empty, push, pop, hs;

  // Ready depends only on registered occupancy, so a producer ignoring it just loses words.
  assign full        = (count_q == els_lp);
  assign empty       = (count_q == '0);
  assign txs_ready_o = !full;
  assign push        = txs_v_i & !full;
  assign pop         = (state_q == E_FILL) & !empty;
  assign hs          = (state_q == E_SEND) & pkt_ready_i;

  assign pkt_o     = pkt_q;
  assign pkt_v_o   = (state_q == E_SEND);
  assign vacancy_o = els_lp - count_q;
  assign isr_txc_o = isr_txc_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    pkt_d      = pkt_q;
    isr_txc_d  = isr_txc_q;

    if (push) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      E_FILL: begin
        if (pop) begin
          pkt_d[word_cnt_q] = mem_q[rd_ptr_q];
          if (word_cnt_q == last_wc_lp) begin
            word_cnt_d = '0;
            state_d    = E_SEND;
          end else begin
            word_cnt_d = word_cnt_q + wc_w_lp'(1);
          end
        end
      end
      E_SEND: begin
        if (pkt_ready_i) state_d = E_FILL;
      end
      default: state_d = E_FILL;
    endcase

    // A handshake outranks a simultaneous clear.
    if (hs)                 isr_txc_d = 1'b1;
    else if (clr_isr_txc_i) isr_txc_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= E_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      pkt_q      <= '0;
      isr_txc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      pkt_q      <= pkt_d;
      isr_txc_q  <= isr_txc_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= txs_i;
  end

`ifdef BSG_MCL_TX_DROP_CNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop = txs_v_i & full;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule
